// File: rtl/data_mem_arbiter.sv
// Two-port req/ack arbiter and sequencer in front of a single-ported data memory.
// Define DMARB_FIXED_PRIO_EN for fixed port-0 priority on ties; round robin otherwise.
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              Busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] DataAddress,
  output logic [DATA_W-1:0] DataMemIn,
  input  logic [DATA_W-1:0] DataMemOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              sel;
  logic              any_req;
  logic              grant1;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifndef DMARB_FIXED_PRIO_EN
  logic              last_grant;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Winner selection: a lone request always wins; ties resolved by priority policy.
  always_comb begin
    state_nxt = state;
    any_req   = Req0 | Req1;
`ifdef DMARB_FIXED_PRIO_EN
    grant1    = Req1 & ~Req0;
`else
    grant1    = Req1 & (~Req0 | ~last_grant);
`endif
    win_wr    = grant1 ? Wr1    : Wr0;
    win_addr  = grant1 ? Addr1  : Addr0;
    win_wdata = grant1 ? WData1 : WData0;

    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory pins, read-data capture and acknowledges are all registered off the state.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sel         <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      DataAddress <= '0;
      DataMemIn   <= '0;
      Ack0        <= 1'b0;
      Ack1        <= 1'b0;
      RData0      <= '0;
      RData1      <= '0;
      Busy        <= 1'b0;
`ifndef DMARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      Busy <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (any_req) begin
            DataAddress <= win_addr;
            DataMemIn   <= win_wdata;
            MemRead     <= ~win_wr;
            MemWrite    <= win_wr;
            sel         <= grant1;
`ifndef DMARB_FIXED_PRIO_EN
            last_grant  <= grant1;
`endif
          end
        end
        ACCESS: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (MemRead) begin
            if (sel) RData1 <= DataMemOut;
            else     RData0 <= DataMemOut;
          end
          Ack0 <= ~sel;
          Ack1 <= sel;
        end
        ACK: begin
          Ack0 <= 1'b0;
          Ack1 <= 1'b0;
        end
        default: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          Ack0     <= 1'b0;
          Ack1     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported `DataMemory`. It shares the memory between the core load/store port (port 0) and the memory loader/debug port (port 1). It accepts one request at a time through a req/ack handshake and drives `MemRead`/`MemWrite`/`DataAddress`/`DataMemIn` for exactly one access cycle. It captures `DataMemOut` and returns it to the granted port with a one-cycle acknowledge.

## Interface
- `ADDR_W`, 8, address width (matches `DataAddress`)
- `DATA_W`, 8, data width (matches `DataMemIn`/`DataMemOut`)

- `CLK`  in  1  clock, rising edge
- `Reset_n`  in  1  reset, asynchronous, active-low
- `Req0` / `Req1`  in  1  access request, port 0 / port 1
- `Wr0` / `Wr1`  in  1  1 = write, 0 = read
- `Addr0` / `Addr1`  in  ADDR_W  access address
- `WData0` / `WData1`  in  DATA_W  write data
- `Ack0` / `Ack1`  out  1  one-cycle completion pulse
- `RData0` / `RData1`  out  DATA_W  read data, valid while AckN=1, held after
- `Busy`  out  1  high in ACCESS and ACK
- `MemRead`  out  1  to `DataMemory`
- `MemWrite`  out  1  to `DataMemory`
- `DataAddress`  out  ADDR_W  to `DataMemory`
- `DataMemIn`  out  DATA_W  to `DataMemory`
- `DataMemOut`  in  DATA_W  from `DataMemory`; combinational read while `MemRead`=1

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - no ReqN → stay in IDLE.
  - any ReqN → select a winner, register its Wr/Addr/WData onto the memory pins, set MemRead = !Wr and MemWrite = Wr, set Sel = winner, go to ACCESS.
- ACCESS: lasts exactly one cycle.
  - Memory write commits at the closing edge.
  - On a read, the closing edge captures `DataMemOut` into RData[Sel].
  - At the closing edge, clear MemRead/MemWrite to 0, set Ack[Sel] to 1, go to ACK.
- ACK: lasts exactly one cycle. At its closing edge, clear Ack[Sel] and go to IDLE.
- Memory pin hold: DataAddress/DataMemIn keep their last value outside ACCESS. MemRead and MemWrite are never both 1.
- Requester rules:
  - Hold Req/Wr/Addr/WData stable from assertion until Ack is seen.
  - Drop Req on the edge that ends the Ack cycle.
  - A Req still high in IDLE after its Ack is treated as a new request.
- Write ack: RDataN is not modified.
- Tie-break: when both ports request in IDLE, grant goes to the port not granted last (round robin). `LastGrant` resets to 1, so port 0 wins the first tie. A lone request always wins regardless of LastGrant.
- Requests arriving during ACCESS/ACK wait in IDLE; none are dropped while held.

## Timing
- Reset (async assert, sync-free release): state=IDLE, LastGrant=1. All outputs are 0: MemRead, MemWrite, DataAddress, DataMemIn, Ack0, Ack1, RData0, RData1, Busy.
- Latency: ReqN sampled high at edge E → ACCESS during cycle E..E+1 → AckN high during E+1..E+2.
- Throughput: one access per 3 cycles. Back-to-back ties alternate ports: 0,1,0,1…
- Reset mid-operation: asserting Reset_n in ACCESS or ACK immediately forces reset values.
  - No Ack is issued.
  - A write may or may not have committed.
  - The requester must re-issue.
- Busy = (state != IDLE), registered.

## Configuration
- `DMARB_FIXED_PRIO_EN`:
  - Defined: ties always go to port 0 (fixed priority) and LastGrant is unused.
  - Undefined (default): round robin as above.
  - All other behaviour is identical.

## Test plan
- Reset: hold Reset_n=0 for 100 ns → every output 0, Busy=0. Release → still idle with no requests.
- Port 0 write then read:
  - Req0=1, Wr0=1, Addr0=8'h01, WData0=8'h03 → one cycle of MemWrite=1, DataAddress=8'h01, DataMemIn=8'h03, then Ack0 one cycle.
  - Then read 8'h01 → MemRead one cycle, Ack0 with RData0=8'h03.
- Simultaneous requests, both held:
  - Port 0 writes 8'hAA to 8'h10; port 1 reads 8'h10.
  - Order (round robin, from reset): port 0 granted first, port 1 second. Ack1 with RData1=8'hAA, 3 cycles after Ack0.
  - With `DMARB_FIXED_PRIO_EN` and continuous Req0: port 1 is never granted.
- Alternation: both ports keep re-requesting for 12 cycles → grant sequence 0,1,0,1. MemRead/MemWrite never both high. Exactly one Ack per 3 cycles.
- Reset mid-access: assert Reset_n=0 while in ACCESS on a port 1 read → MemRead drops immediately, no Ack1, RData1=0, state IDLE after release.
- Request during busy: Req1 rises during a port 0 ACK cycle → port 1 granted on the next edge in IDLE. Ack1 arrives 2 cycles after that edge.
